// File: rtl/alu_arbiter_pkg.sv
// Shared types and ALU helpers for the two-requester arbitrated ALU.
package alu_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int NUM_REQ = 2;
  localparam int OP_W    = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_ZERO = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
  } flags_t;

  function automatic logic [DATA_W-1:0] alu_result(input op_e op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SHL:  r = {a[DATA_W-2:0], 1'b0};
      OP_SHR:  r = {1'b0, a[DATA_W-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  // For modular add, the carry-out is set exactly when the wrapped sum is below A.
  function automatic flags_t alu_flags(input op_e op,
                                       input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b,
                                       input logic [DATA_W-1:0] r);
    flags_t f;
    f.zero  = (r == '0);
    f.carry = 1'b0;
    f.ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        f.carry = (r < a);
        f.ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        f.carry = (a < b);
        f.ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      default: ;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; combinational, rr_i selects the winner on a tie.
module rr_arb2
  import alu_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               rr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = rr_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin shared ALU, one op in flight: accept at T, one-hot rsp_valid at T+2, held until owner's rsp_ready.
// Requests wait with req_ready=0 while busy; flag outputs are live only with ALU_ARBITER_FLAGS_EN defined.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic                      rsp_carry,
  output logic                      rsp_ovf,
  output logic                      busy
);

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  op_e                 op_q, op_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic [NUM_REQ-1:0]  gnt;
  logic                gnt_idx;
  logic                accept;
  logic                rsp_fire;

  rr_arb2 u_rr_arb2 (
    .req_i (req_valid),
    .rr_i  (rr_q),
    .gnt_o (gnt)
  );

  assign gnt_idx  = gnt[1];
  assign accept   = (state_q == ST_IDLE) && (|gnt);
  assign rsp_fire = (state_q == ST_RESP) && rsp_ready[owner_q];

  // The state register already reads IDLE during reset, so ready is gated by rst_n directly.
  assign req_ready  = (rst_n && state_q == ST_IDLE) ? gnt : '0;
  assign rsp_valid  = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : '0;
  assign rsp_result = result_q;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EXEC;
          rr_d    = ~gnt_idx;
          owner_d = gnt_idx;
          a_d     = gnt_idx ? req_a[DATA_W +: DATA_W] : req_a[0 +: DATA_W];
          b_d     = gnt_idx ? req_b[DATA_W +: DATA_W] : req_b[0 +: DATA_W];
          op_d    = op_e'(gnt_idx ? req_op[OP_W +: OP_W] : req_op[0 +: OP_W]);
        end
      end
      ST_EXEC: begin
        result_d = alu_result(op_q, a_q, b_q);
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

`ifdef ALU_ARBITER_FLAGS_EN
  flags_t flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (state_q == ST_EXEC) begin
      flags_d = alu_flags(op_q, a_q, b_q, alu_result(op_q, a_q, b_q));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign rsp_zero  = flags_q.zero;
  assign rsp_carry = flags_q.carry;
  assign rsp_ovf   = flags_q.ovf;
`else
  assign rsp_zero  = 1'b0;
  assign rsp_carry = 1'b0;
  assign rsp_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single-requester ops plus arbitration/handshake/reset sequences.
module tb_alu_arbiter;

`ifdef ALU_ARBITER_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [5:0]  req_op;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_carry;
  logic        rsp_ovf;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[r*3 +: 3]  = op;
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req_ready"},  {30'd0, req_ready}, 32'd0);
    check({tag, " rsp_valid"},  {30'd0, rsp_valid}, 32'd0);
    check({tag, " rsp_result"}, rsp_result, 32'd0);
    check({tag, " flags"},      {29'd0, rsp_zero, rsp_carry, rsp_ovf}, 32'd0);
    check({tag, " busy"},       {31'd0, busy}, 32'd0);
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic run_op(input string tag, input logic [1:0] vld, input logic [1:0] exp_gnt,
                        input logic [31:0] exp_res, input logic z, input logic c, input logic o);
    req_valid = vld;
    #1;
    check({tag, " grant"}, {30'd0, req_ready}, {30'd0, exp_gnt});
    @(posedge clk);
    @(negedge clk);
    check({tag, " exec busy"},  {31'd0, busy}, 32'd1);
    check({tag, " exec ready"}, {30'd0, req_ready}, 32'd0);
    check({tag, " exec rsp"},   {30'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, " rsp_valid"}, {30'd0, rsp_valid}, {30'd0, exp_gnt});
    check({tag, " result"},    rsp_result, exp_res);
    check({tag, " flags"},     {29'd0, rsp_zero, rsp_carry, rsp_ovf}, {29'd0, z & FL, c & FL, o & FL});
    rsp_ready = exp_gnt;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
    check({tag, " done rsp"},  {30'd0, rsp_valid}, 32'd0);
    check({tag, " done busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vt[0]  = '{0, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vt[1]  = '{1, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    vt[2]  = '{0, 3'b001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{1, 3'b001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{0, 3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1, 3'b011, 32'h0F0F_0000, 32'h0000_F0F0, 32'h0F0F_F0F0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{0, 3'b100, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1, 3'b101, 32'h8000_0001, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{0, 3'b110, 32'h8000_0001, 32'h0000_0003, 32'h4000_0000, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1, 3'b111, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vt[10] = '{0, 3'b001, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b0, 1'b0};

    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);

    // Tie immediately after reset: req0 wins first, then strict alternation.
    set_req(0, 3'b000, 32'h0000_0001, 32'h0000_0002);
    set_req(1, 3'b001, 32'h8000_0000, 32'h0000_0001);
    rst_n = 1'b1;
    run_op("tie1", 2'b11, 2'b01, 32'h0000_0003,  1'b0, 1'b0, 1'b0);
    run_op("tie2", 2'b11, 2'b10, 32'h7FFF_FFFF,  1'b0, 1'b0, 1'b1);
    run_op("tie3", 2'b11, 2'b01, 32'h0000_0003,  1'b0, 1'b0, 1'b0);
    run_op("tie4", 2'b11, 2'b10, 32'h7FFF_FFFF,  1'b0, 1'b0, 1'b1);
    req_valid = 2'b00;

    for (int i = 0; i < 11; i++) begin
      set_req(vt[i].r, vt[i].op, vt[i].a, vt[i].b);
      set_req(1 - vt[i].r, 3'b000, ~vt[i].a, ~vt[i].b);
      run_op($sformatf("vec%0d", i), (vt[i].r == 1) ? 2'b10 : 2'b01,
             (vt[i].r == 1) ? 2'b10 : 2'b01, vt[i].res, vt[i].z, vt[i].c, vt[i].o);
      req_valid = 2'b00;
    end

    // Non-owner rsp_ready must not release RESP; pending requests wait.
    set_req(0, 3'b000, 32'h0000_0010, 32'h0000_0020);
    req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b10;
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold%0d rsp_valid", k), {30'd0, rsp_valid}, 32'd1);
      check($sformatf("hold%0d result", k), rsp_result, 32'h0000_0030);
      check($sformatf("hold%0d ready", k), {30'd0, req_ready}, 32'd0);
    end
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    #1;
    check("release ready", {30'd0, req_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
    check("release rsp", {30'd0, rsp_valid}, 32'd0);
    check("release busy", {31'd0, busy}, 32'd0);
    check("release next grant", {30'd0, req_ready}, 32'd2);
    req_valid = 2'b00;

    // rr now points at req1; reset during EXEC must drop the op and restore rr=0.
    set_req(0, 3'b000, 32'h0000_0011, 32'h0000_0022);
    set_req(1, 3'b010, 32'hFFFF_FFFF, 32'h0000_FFFF);
    req_valid = 2'b11;
    #1;
    check("pre-reset grant", {30'd0, req_ready}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    check("pre-reset exec", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midexec reset");
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("post-reset%0d rsp", k), {30'd0, rsp_valid}, 32'd0);
      check($sformatf("post-reset%0d busy", k), {31'd0, busy}, 32'd0);
    end
    run_op("post-reset tie", 2'b11, 2'b01, 32'h0000_0033, 1'b0, 1'b0, 1'b0);
    req_valid = 2'b00;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
